avl_arbiter2: RTL and testbench

//  Two-master Avalon-MM arbiter sharing one slave port between requesters.
//  m0 is the core data master (core2avl); m1 is a second requester (DMA/debug loader).

---
 rtl/avl_arbiter2.sv | 120 ++++++++++++
 tb/tb_avl_arbiter2.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/avl_arbiter2.sv
// Two-master Avalon-MM round-robin arbiter onto one slave port; optional AVL_ARB_LOCK_EN adds m0_lock/m1_lock.
// Latency: one registered arbitration cycle before the slave strobe, then slave-paced (minimum 2 cycles per transfer).
// Backpressure: the granted master sees avl_waitrequest and the other master is held with waitrequest=1.
module avl_arbiter2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_waitrequest,
`ifdef AVL_ARB_LOCK_EN
    input  logic                    m0_lock,
    input  logic                    m1_lock,
`endif
    output logic [ADDR_WIDTH-1:0]   avl_address,
    output logic [DATA_WIDTH/8-1:0] avl_byteenable,
    output logic                    avl_read,
    output logic                    avl_write,
    output logic [DATA_WIDTH-1:0]   avl_writedata,
    input  logic [DATA_WIDTH-1:0]   avl_readdata,
    input  logic                    avl_waitrequest
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state;
    logic   last_gnt;
    logic   req0, req1;
    logic   hold0, hold1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef AVL_ARB_LOCK_EN
    assign hold0 = m0_lock;
    assign hold1 = m1_lock;
`else
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the master that did not win last time goes next.
                    if (req0 && (!req1 || last_gnt)) begin
                        state    <= GNT0;
                        last_gnt <= 1'b0;
                    end else if (req1) begin
                        state    <= GNT1;
                        last_gnt <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!req0)
                        state <= IDLE;
                    else if (!avl_waitrequest && !hold0)
                        state <= IDLE;
                end
                GNT1: begin
                    if (!req1)
                        state <= IDLE;
                    else if (!avl_waitrequest && !hold1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m0_readdata = avl_readdata;
    assign m1_readdata = avl_readdata;

    always_comb begin
        avl_address    = '0;
        avl_byteenable = '0;
        avl_read       = 1'b0;
        avl_write      = 1'b0;
        avl_writedata  = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state)
            GNT0: begin
                avl_address    = m0_address;
                avl_byteenable = m0_byteenable;
                avl_read       = m0_read;
                avl_write      = m0_write;
                avl_writedata  = m0_writedata;
                m0_waitrequest = avl_waitrequest;
            end
            GNT1: begin
                avl_address    = m1_address;
                avl_byteenable = m1_byteenable;
                avl_read       = m1_read;
                avl_write      = m1_write;
                avl_writedata  = m1_writedata;
                m1_waitrequest = avl_waitrequest;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avl_arbiter2.sv
// Bench for avl_arbiter2: per-cycle vector table fed through an expected-result queue.
module tb_avl_arbiter2;

    localparam int DW = 32;
    localparam int AW = 32;

    localparam logic [AW-1:0]   A0 = 32'h0000_0100;
    localparam logic [AW-1:0]   A1 = 32'h0000_0200;
    localparam logic [DW-1:0]   D0 = 32'hDEAD_BEEF;
    localparam logic [DW-1:0]   D1 = 32'hCAFE_F00D;
    localparam logic [DW/8-1:0] B0 = 4'hF;
    localparam logic [DW/8-1:0] B1 = 4'h3;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   m0_address, m1_address, avl_address;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable, avl_byteenable;
    logic            m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0]   m0_writedata, m1_writedata, avl_writedata;
    logic [DW-1:0]   m0_readdata, m1_readdata, avl_readdata;
    logic            m0_waitrequest, m1_waitrequest;
    logic            avl_read, avl_write, avl_waitrequest;
    logic            m0_lock, m1_lock;

    always #5 clk = ~clk;

    avl_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
`ifdef AVL_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .avl_address(avl_address), .avl_byteenable(avl_byteenable),
        .avl_read(avl_read), .avl_write(avl_write), .avl_writedata(avl_writedata),
        .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest)
    );

    // One row = one clock cycle: inputs driven, outputs expected during that cycle.
    // sel: which master the slave port should mirror (0 none, 1 m0, 2 m1).
    typedef struct {
        logic        rst, r0, w0, r1, w1, l0, l1, sw;
        logic [31:0] rd;
        logic [1:0]  sel;
        logic        ar, aw, wq0, wq1;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic        ar, aw, wq0, wq1;
        logic [31:0] rd;
        int          row;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(logic rst, logic r0, logic w0, logic r1, logic w1,
                                logic l0, logic l1, logic sw, logic [31:0] rd,
                                logic [1:0] sel, logic ar, logic aw, logic wq0, logic wq1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
        v.l0 = l0; v.l1 = l1; v.sw = sw; v.rd = rd;
        v.sel = sel; v.ar = ar; v.aw = aw; v.wq0 = wq0; v.wq1 = wq1;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
        end
    endtask

    task automatic compare_outputs(exp_t e);
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        logic [DW/8-1:0] eb;
        ea = (e.sel == 2'd1) ? A0 : (e.sel == 2'd2) ? A1 : '0;
        ed = (e.sel == 2'd1) ? D0 : (e.sel == 2'd2) ? D1 : '0;
        eb = (e.sel == 2'd1) ? B0 : (e.sel == 2'd2) ? B1 : '0;
        check("avl_read",       e.row, 32'(avl_read),       32'(e.ar));
        check("avl_write",      e.row, 32'(avl_write),      32'(e.aw));
        check("avl_address",    e.row, avl_address,         ea);
        check("avl_writedata",  e.row, avl_writedata,       ed);
        check("avl_byteenable", e.row, 32'(avl_byteenable), 32'(eb));
        check("m0_waitrequest", e.row, 32'(m0_waitrequest), 32'(e.wq0));
        check("m1_waitrequest", e.row, 32'(m1_waitrequest), 32'(e.wq1));
        check("m0_readdata",    e.row, m0_readdata,         e.rd);
        check("m1_readdata",    e.row, m1_readdata,         e.rd);
    endtask

    task automatic apply(vec_t v, int row);
        exp_t e;
        @(posedge clk);
        #1;
        reset = v.rst; m0_read = v.r0; m0_write = v.w0; m1_read = v.r1; m1_write = v.w1;
        m0_lock = v.l0; m1_lock = v.l1; avl_waitrequest = v.sw; avl_readdata = v.rd;
        e.sel = v.sel; e.ar = v.ar; e.aw = v.aw; e.wq0 = v.wq0; e.wq1 = v.wq1;
        e.rd = v.rd; e.row = row;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard row %0d: queue empty, expected 1 entry", row);
        end else begin
            compare_outputs(sb.pop_front());
        end
    endtask

    initial begin
        exp_t e0;
        reset = 1'b1;
        m0_address = A0; m0_byteenable = B0; m0_writedata = D0;
        m1_address = A1; m1_byteenable = B1; m1_writedata = D1;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_lock = 0; m1_lock = 0;
        avl_waitrequest = 0; avl_readdata = 32'h5A5A_0001;

        //   rst r0 w0 r1 w1 l0 l1 sw  rd            sel ar aw wq0 wq1
        // single m0 write, slave ready
        add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0011, 1, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        // both reading continuously: m0, m1, m0, m1 with an idle cycle between grants
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'hA000_0000, 1, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'hA000_0001, 2, 1, 0, 1, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'hA000_0002, 1, 1, 0, 0, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'hA000_0003, 2, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        // m1 read with a 3-cycle slave stall
        add(0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 2, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 2, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 2, 1, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 32'h1234_5678, 2, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        // reset while GNT1 is stalled, then a tie goes to m0
        add(0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(1, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0000, 2, 1, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 1, 0, 0, 0, 0, 32'hB000_0000, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        // m0 abandons its read mid-stall
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 0, 1, 1);
        // read and write together pass straight through
        add(0, 0, 0, 1, 1, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 32'hC000_0000, 2, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
`ifdef AVL_ARB_LOCK_EN
        // locked m0 writes back-to-back while m1 waits; lock low on the third
        add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 1, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 0, 1, 1, 0, 1, 0, 0, 32'h0000_0000, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1, 0, 0, 32'h0000_0000, 1, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 0, 0, 0, 32'h0000_0000, 1, 1, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 32'hD000_0000, 2, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 1, 1);
`endif

        // reset state, checked by hand before the table runs
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        e0.sel = 0; e0.ar = 0; e0.aw = 0; e0.wq0 = 1; e0.wq1 = 1;
        e0.rd = 32'h5A5A_0001; e0.row = -1;
        compare_outputs(e0);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
